// File: rtl/char_buffer_16x16_if.sv
//----------------------------------------------------------------------------
// Module      : char_buffer_16x16_if
// Description : Write handshake and character read port of the 16x16
//               character buffer, bundled for the producer/renderer side.
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

interface char_buffer_16x16_if;
  logic       wr_valid;
  logic       wr_ready;
  logic [7:0] wr_char;
  logic [7:0] char_xy;
  logic [6:0] char_code;

  // Producer / renderer side: offers bytes and issues read addresses
  modport master (
    output wr_valid,
    output wr_char,
    output char_xy,
    input  wr_ready,
    input  char_code
  );

  // Buffer side
  modport slave (
    input  wr_valid,
    input  wr_char,
    input  char_xy,
    output wr_ready,
    output char_code
  );
endinterface

`default_nettype wire

// File: rtl/char_buffer_16x16.sv
//----------------------------------------------------------------------------
// Module      : char_buffer_16x16
// Description : Writable 16x16 character buffer with hardware cursor,
//               control-code decoding and a 256-cycle clear sweep.
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module char_buffer_16x16 #(
  parameter logic [6:0] CLEAR_CODE = 7'h20
) (
  input  wire logic              clk,
  input  wire logic              rst,      // asynchronous, active low
  char_buffer_16x16_if.slave     bus,
  input  wire logic              clr,
  output logic [3:0]             cursor_x,
  output logic [3:0]             cursor_y,
  output logic                   busy
);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  localparam logic [7:0] c_LF = 8'h0A;
  localparam logic [7:0] c_CR = 8'h0D;
  localparam logic [7:0] c_BS = 8'h08;
  localparam logic [7:0] c_FF = 8'h0C;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_clr_cnt;
  logic [7:0] w_clr_cnt_nxt;
  logic [3:0] r_cur_x;
  logic [3:0] r_cur_y;
  logic [3:0] w_cur_x_nxt;
  logic [3:0] w_cur_y_nxt;
  logic       w_we;
  logic [7:0] w_waddr;
  logic [6:0] w_wdata;

  // Cell storage, index {x,y}; initialised by the clear sweep, not by reset
  logic [6:0] r_mem [256];

  // State, sweep counter and cursor registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_CLEAR;
      r_clr_cnt <= 8'd0;
      r_cur_x   <= 4'd0;
      r_cur_y   <= 4'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_cnt <= w_clr_cnt_nxt;
      r_cur_x   <= w_cur_x_nxt;
      r_cur_y   <= w_cur_y_nxt;
    end
  end

  // Next state, cursor movement and the single array write port
  always_comb begin
    w_state_nxt   = r_state;
    w_clr_cnt_nxt = r_clr_cnt;
    w_cur_x_nxt   = r_cur_x;
    w_cur_y_nxt   = r_cur_y;
    w_we          = 1'b0;
    w_waddr       = {r_cur_x, r_cur_y};
    w_wdata       = CLEAR_CODE;

    if (clr) begin
      // Clear request wins over everything, including a running sweep
      w_state_nxt   = ST_CLEAR;
      w_clr_cnt_nxt = 8'd0;
      w_cur_x_nxt   = 4'd0;
      w_cur_y_nxt   = 4'd0;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          w_we          = 1'b1;
          w_waddr       = r_clr_cnt;
          w_clr_cnt_nxt = r_clr_cnt + 8'd1;
          if (r_clr_cnt == 8'hFF) begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_IDLE: begin
          if (bus.wr_valid) begin
            if (bus.wr_char >= 8'h20 && bus.wr_char <= 8'h7E) begin
              // Printable: store at cursor, advance with row wrap
              w_we        = 1'b1;
              w_wdata     = bus.wr_char[6:0];
              w_cur_x_nxt = r_cur_x + 4'd1;
              if (r_cur_x == 4'hF) begin
                w_cur_y_nxt = r_cur_y + 4'd1;
              end
            end else begin
              case (bus.wr_char)
                c_LF: begin
                  w_cur_x_nxt = 4'd0;
                  w_cur_y_nxt = r_cur_y + 4'd1;
                end
                c_CR: begin
                  w_cur_x_nxt = 4'd0;
                end
                c_BS: begin
                  // Step back (across a row if needed) and blank that cell
                  if (r_cur_x != 4'd0) begin
                    w_cur_x_nxt = r_cur_x - 4'd1;
                    w_we        = 1'b1;
                    w_waddr     = {r_cur_x - 4'd1, r_cur_y};
                  end else if (r_cur_y != 4'd0) begin
                    w_cur_x_nxt = 4'hF;
                    w_cur_y_nxt = r_cur_y - 4'd1;
                    w_we        = 1'b1;
                    w_waddr     = {4'hF, r_cur_y - 4'd1};
                  end
                end
                c_FF: begin
                  w_state_nxt   = ST_CLEAR;
                  w_clr_cnt_nxt = 8'd0;
                  w_cur_x_nxt   = 4'd0;
                  w_cur_y_nxt   = 4'd0;
                end
                default: begin
                  // Unlisted codes are consumed without effect
                end
              endcase
            end
          end
        end
        default: begin
          w_state_nxt = ST_CLEAR;
        end
      endcase
    end
  end

  // Array write port
  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[w_waddr] <= w_wdata;
    end
  end

  assign bus.char_code = r_mem[bus.char_xy];
  assign bus.wr_ready  = (r_state == ST_IDLE) && !clr;
  assign busy          = (r_state == ST_CLEAR);
  assign cursor_x      = r_cur_x;
  assign cursor_y      = r_cur_y;

endmodule

`default_nettype wire

// File: doc/char_buffer_16x16.md
# char_buffer_16x16

Writable 16x16 character buffer: the producer side of the character-cell display path. It accepts a byte stream (ASCII text plus a few control codes) over a valid/ready handshake, places characters at a hardware cursor, and serves the stored 7-bit code on a `char_xy` → `char_code` read port. That read port drops in wherever the static 16x16 character ROM feeds the character renderer. The write side typically connects to a UART/keyboard receiver or a game-logic text generator.

## Interface
Parameters:
- CLEAR_CODE, 7'h20, code written to every cell by a clear (space)

Ports:
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  asynchronous, active-low reset (asserted when 0)
- wr_valid  in  1  byte on `wr_char` is offered
- wr_ready  out  1  block can accept a byte this cycle
- wr_char  in  8  byte to write; printable or control code
- clr  in  1  synchronous clear request, single-cycle pulse or level
- char_xy  in  8  read address, {x[3:0], y[3:0]}; x = column, y = row
- char_code  out  7  code stored at `char_xy`; combinational read
- cursor_x  out  4  current write column
- cursor_y  out  4  current write row
- busy  out  1  high while a clear sweep runs

## Operation
- Storage: 256 x 7-bit array, index {x,y}. Not reset directly; the clear sweep initialises it.
- FSM states:
  - CLEAR: writes CLEAR_CODE to cell `clr_cnt`, then increments `clr_cnt` (8 bits). After writing cell 255 → IDLE.
  - IDLE: accepts bytes.
- Reset (rst=0, asynchronous): state=CLEAR, clr_cnt=0, cursor=(0,0), wr_ready=0, busy=1. char_code follows the array; contents are undefined until the sweep ends.
- wr_ready = (state==IDLE) && !clr. busy = (state==CLEAR).
- Transfer occurs when wr_valid && wr_ready. Each accepted byte is decoded as follows:
  - 0x20..0x7E: write wr_char[6:0] at cursor, then advance the cursor.
  - 0x0A (LF): x=0, y=y+1.
  - 0x0D (CR): x=0; y unchanged.
  - 0x08 (BS):
    - If x>0: x=x-1, then write CLEAR_CODE at the new position.
    - If x==0 and y>0: move to (15, y-1) and blank that cell.
    - At (0,0): no-op.
  - 0x0C (FF): cursor=(0,0), clr_cnt=0, state=CLEAR.
  - Any other value (0x00-0x1F not listed above, 0x7F, 0x80-0xFF): consumed, no effect.
- Advance rule: x=x+1. If x was 15: x=0, y=y+1. All row arithmetic wraps mod 16, so (15,15) advances to (0,0). No scrolling.
- clr=1 in any state: next edge sets state=CLEAR, clr_cnt=0, cursor=(0,0). A clr during CLEAR restarts the sweep from cell 0. Because wr_ready is gated by clr, no byte is lost.
- Writes and clears never block the read port. A read during CLEAR returns a mix of old and cleared cells.

## Timing
- Byte accepted at edge N: array and cursor are updated at that edge. char_code at that cell and cursor_x/y reflect the update in cycle N+1.
- Throughput in IDLE is 1 byte/cycle, including control codes.
- Read latency is 0 cycles: char_code is combinational from char_xy, so the renderer's existing pipeline alignment is unchanged.
- Clear sweep: after the edge that samples clr or FF, or after reset release, wr_ready is low for exactly 256 cycles. It rises in the cycle after cell 255 is written.
- rst assertion mid-sweep or mid-stream takes effect immediately (asynchronously). A byte offered in that cycle is dropped.

## Test plan
- Reset then idle: release rst, hold wr_valid=0 → busy=1 and wr_ready=0 for 256 cycles, then wr_ready=1. All 256 reads return 7'h20. cursor=(0,0).
- Text write: send "AB" back-to-back → cell {0,0}=7'h41, cell {1,0}=7'h42, cursor=(2,0). Each byte is accepted in one cycle, and the read is visible the next cycle.
- Wrap: send 16 'X' with CR/LF, then 256 printable bytes from (0,0) → cursor ends at (0,0). Byte 17 of the printable run lands at (0,1). Nothing is written outside the array.
- Controls:
  - At (3,2): BS → cursor (2,2), cell {2,2}=7'h20.
  - At (0,2): BS → cursor (15,1).
  - At (0,0): BS → unchanged.
  - Byte 0x07 → no change.
  - CR at (9,4) → (0,4).
- FF and clr: fill cells, send 0x0C → 256-cycle ready-low sweep, all cells 7'h20, cursor (0,0). Pulse clr at sweep cycle 100 → sweep restarts and ready stays low 256 more cycles. clr and wr_valid together in IDLE → wr_ready=0, byte not consumed.
- Async reset mid-stream: assert rst between edges while writing → cursor and outputs go to reset values before the next edge, and the sweep restarts after release.
